// File: rtl/serial_carry_resolver.sv
// Resolves the ripple carry over an LSB-first half-adder bit stream and presents the summed word on a valid/ready output.
// Build option SERIAL_SAT_EN: a word whose final carry is set loads all ones instead of the wrapped sum.
module serial_carry_resolver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             sum_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] word_data,
    output logic             word_carry,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_word_data;
    logic             r_word_carry;
    logic             r_word_valid;

    logic             w_r;
    logic             w_c_next;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_word_next;
    logic             w_last;
    logic             w_accept;

    // Full-adder completion of the half-adder pair: s^c for the result, a&b | (a^b)&c for the carry.
    assign w_r          = sum_in ^ r_c;
    assign w_c_next     = carry_in | (sum_in & r_c);
    assign w_shift_next = {w_r, r_shift[WIDTH-1:1]};
    assign w_last       = (r_cnt == LAST_POS);
    assign w_accept     = r_word_valid & word_ready;

`ifdef SERIAL_SAT_EN
    assign w_word_next = w_c_next ? {WIDTH{1'b1}} : w_shift_next;
`else
    assign w_word_next = w_shift_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_c          <= 1'b0;
            r_shift      <= '0;
            r_word_data  <= '0;
            r_word_carry <= 1'b0;
            r_word_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_COLLECT;
                        r_cnt   <= '0;
                        r_c     <= 1'b0;
                        r_shift <= '0;
                    end
                end
                S_COLLECT: begin
                    // Abort wins over a coincident data bit, which is dropped.
                    if (start) begin
                        r_cnt   <= '0;
                        r_c     <= 1'b0;
                        r_shift <= '0;
                    end else if (bit_valid) begin
                        r_shift <= w_shift_next;
                        r_c     <= w_c_next;
                        if (w_last) begin
                            r_cnt        <= '0;
                            r_word_data  <= w_word_next;
                            r_word_carry <= w_c_next;
                            r_word_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_word_valid <= 1'b0;
                        if (start) begin
                            r_state <= S_COLLECT;
                            r_cnt   <= '0;
                            r_c     <= 1'b0;
                            r_shift <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_word_valid <= 1'b0;
                end
            endcase
        end
    end

    assign word_data  = r_word_data;
    assign word_carry = r_word_carry;
    assign word_valid = r_word_valid;
    assign busy       = (r_state == S_COLLECT) || (r_state == S_HOLD);

endmodule
